// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the multi-cycle shift sequencer:
//   - shift mode encodings carried on the 2-bit ctrl bus
//   - sequencer state encoding
//   - a small helper that tells whether a mode modifies the operand
// -----------------------------------------------------------------------------
package shift_pkg;

  // Shift modes on the ctrl bus
  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b11;
  localparam logic [1:0] SH_PASS = 2'b10;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // True for every mode that actually moves bits
  function automatic logic mode_moves(input logic [1:0] mode);
    logic moves;
    case (mode)
      SH_SLL:  moves = 1'b1;
      SH_SRL:  moves = 1'b1;
      SH_SRA:  moves = 1'b1;
      default: moves = 1'b0;
    endcase
    return moves;
  endfunction

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// One stage of the barrel shifter: shifts the operand by 2^idx_i in the given
// mode, or passes it through unchanged when en_i is low or mode is SH_PASS.
// Purely combinational.
// Ports:
//   data_i  [WIDTH]    operand
//   mode_i  [2]        shift mode (SH_SLL / SH_SRL / SH_SRA / SH_PASS)
//   idx_i   [SHAMT_W]  stage index; shift distance is 2^idx_i
//   en_i    [1]        stage enable (the corresponding shamt bit)
//   data_o  [WIDTH]    stage result
// -----------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [1:0]         mode_i,
  input  logic [SHAMT_W-1:0] idx_i,
  input  logic               en_i,
  output logic [WIDTH-1:0]   data_o
);

  // Distance 2^idx; idx never exceeds SHAMT_W-1 so the value fits SHAMT_W bits.
  logic [SHAMT_W-1:0] dist_s;

  // Stage shift selected by mode; SRA replicates the current top bit.
  always_comb begin
    dist_s = SHAMT_W'(1) << idx_i;
    data_o = data_i;
    if (en_i && mode_moves(mode_i)) begin
      case (mode_i)
        SH_SLL:  data_o = data_i << dist_s;
        SH_SRL:  data_o = data_i >> dist_s;
        SH_SRA:  data_o = $signed(data_i) >>> dist_s;
        default: data_o = data_i;
      endcase
    end else begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq
// Multi-cycle sequencer around a single shift_step stage. A request latches
// operand, amount and mode, then applies the 16/8/4/2/1 stages one per clock
// (most significant shamt bit first). Latency is fixed at SHAMT_W+1 cycles
// from acceptance to the done pulse, independent of shamt and mode.
// Ports:
//   clk    [1]        clock, rising edge
//   rst    [1]        asynchronous active-high reset
//   start  [1]        request strobe, accepted when start && ready && !flush
//   ready  [1]        idle or done; a request can be accepted
//   ctrl   [2]        mode: 00 SLL, 01 SRL, 11 SRA, 10 pass-through
//   shamt  [SHAMT_W]  shift amount
//   din    [WIDTH]    operand
//   flush  [1]        abort in-flight operation / block acceptance
//   busy   [1]        shifting
//   done   [1]        one-cycle pulse, dout valid
//   dout   [WIDTH]    result register, held until the next completion
// -----------------------------------------------------------------------------
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [1:0]         ctrl,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;

  logic [WIDTH-1:0]   step_out_s;
  logic               accept_s;

  // The one shared stage, indexed by the down-counter.
  shift_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .data_i (acc_q),
    .mode_i (ctrl_q),
    .idx_i  (cnt_q),
    .en_i   (shamt_q[cnt_q]),
    .data_o (step_out_s)
  );

  // Status outputs decode only from the state register.
  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign dout  = dout_q;

  // Acceptance needs no flush; start while shifting is simply not seen.
  assign accept_s = start && !flush && ready;

  // Next-state, datapath and result update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shamt_d = shamt_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          acc_d   = din;
          shamt_d = shamt;
          ctrl_d  = ctrl;
          cnt_d   = SHAMT_W'(SHAMT_W - 1);
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          // Abort: result register keeps the last completed value.
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          acc_d   = step_out_s;
          dout_d  = step_out_s;
          state_d = ST_DONE;
        end else begin
          acc_d   = step_out_s;
          cnt_d   = cnt_q - SHAMT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      shamt_q <= '0;
      ctrl_q  <= SH_SLL;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shamt_q <= shamt_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq
// Directed, table-driven bench for shift_seq plus hand-written sequences for
// flush, back-to-back, busy-start and reset corner cases.
// -----------------------------------------------------------------------------
module tb_shift_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ready;
  logic [1:0]  ctrl;
  logic [4:0]  shamt;
  logic [31:0] din;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  int checks;
  int errors;

  shift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ready (ready),
    .ctrl  (ctrl),
    .shamt (shamt),
    .din   (din),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  ctrl;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // Present a request in the current cycle (caller is at a negedge).
  task automatic issue(input logic [1:0] c, input logic [4:0] s, input logic [31:0] d);
    start = 1'b1;
    ctrl  = c;
    shamt = s;
    din   = d;
  endtask

  // Called at the negedge of the acceptance cycle t. Walks t+1..t+5 checking
  // the SHIFT phase, scrambling inputs to prove they are ignored, then checks
  // done and dout at t+6. Ends at the negedge of cycle t+6.
  task automatic expect_done(input string nm, input logic [31:0] exp, input bit poke_start);
    @(negedge clk);
    start = 1'b0;
    din   = ~din;
    shamt = ~shamt;
    ctrl  = ~ctrl;
    for (int k = 1; k <= 5; k++) begin
      if (poke_start) start = (k == 2);
      chk({nm, " busy"},  {31'd0, busy},  32'd1);
      chk({nm, " done0"}, {31'd0, done},  32'd0);
      chk({nm, " ready0"}, {31'd0, ready}, 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, " done"},  {31'd0, done},  32'd1);
    chk({nm, " dout"},  dout,           exp);
    chk({nm, " ready"}, {31'd0, ready}, 32'd1);
  endtask

  int pulses;

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    ctrl  = 2'b00;
    shamt = 5'd0;
    din   = 32'd0;

    vecs[0] = '{"sll31",    2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000};
    vecs[1] = '{"sra4",     2'b11, 5'd4,  32'h8000_0000, 32'hF800_0000};
    vecs[2] = '{"srl4",     2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000};
    vecs[3] = '{"pass17",   2'b10, 5'd17, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4] = '{"sll0",     2'b00, 5'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[5] = '{"sra31",    2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[6] = '{"srl8",     2'b01, 5'd8,  32'hF000_000F, 32'h00F0_0000};
    vecs[7] = '{"sll12",    2'b00, 5'd12, 32'h0000_00FF, 32'h000F_F000};
    vecs[8] = '{"sra3pos",  2'b11, 5'd3,  32'h7FFF_FFFF, 32'h0FFF_FFFF};
    vecs[9] = '{"sll4",     2'b00, 5'd4,  32'h0000_000F, 32'h0000_00F0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst busy",  {31'd0, busy},  32'd0);
    chk("rst done",  {31'd0, done},  32'd0);
    chk("rst dout",  dout,           32'd0);
    rst = 1'b0;

    // Table-driven operations
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(vecs[i].ctrl, vecs[i].shamt, vecs[i].din);
      expect_done(vecs[i].name, vecs[i].exp, (i == 6));
      @(negedge clk);
      chk({vecs[i].name, " pulse"}, {31'd0, done}, 32'd0);
      chk({vecs[i].name, " idle"},  {31'd0, ready}, 32'd1);
    end

    // Flush in the third SHIFT cycle: dout keeps 0xF0, no done
    @(negedge clk);
    issue(2'b00, 5'd5, 32'h0000_0001);
    @(negedge clk); start = 1'b0;   // SHIFT 1
    @(negedge clk);                 // SHIFT 2
    @(negedge clk); flush = 1'b1;   // SHIFT 3
    @(negedge clk); flush = 1'b0;
    chk("flush busy",  {31'd0, busy},  32'd0);
    chk("flush ready", {31'd0, ready}, 32'd1);
    chk("flush done",  {31'd0, done},  32'd0);
    chk("flush dout",  dout,           32'h0000_00F0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("flush no done", pulses, 0);
    chk("flush dout hold", dout, 32'h0000_00F0);

    // Back-to-back: second done exactly six cycles after the first
    @(negedge clk);
    issue(2'b01, 5'd31, 32'h8000_0000);
    expect_done("b2b first", 32'h0000_0001, 1'b0);
    issue(2'b00, 5'd5, 32'h0000_0003);
    expect_done("b2b second", 32'h0000_0060, 1'b0);

    // Flush in DONE blocks acceptance but the pulse already stands
    issue(2'b00, 5'd1, 32'h0000_0001);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("dflush busy",  {31'd0, busy},  32'd0);
    chk("dflush ready", {31'd0, ready}, 32'd1);
    chk("dflush dout",  dout,           32'h0000_0060);

    // Reset mid-SHIFT: immediate clear, no done afterwards
    @(negedge clk);
    issue(2'b00, 5'd1, 32'h0000_0001);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst dout",  dout,           32'd0);
    chk("arst done",  {31'd0, done},  32'd0);
    chk("arst busy",  {31'd0, busy},  32'd0);
    chk("arst ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("arst no done", pulses, 0);
    chk("arst dout hold", dout, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle sequencer for the shared 32-bit barrel-shift datapath. It accepts one shift request, latches operand, amount and mode, and applies the five power-of-two stages (16, 8, 4, 2, 1) one per clock. A single small stage then serves every shift amount instead of a full five-level combinational shifter. It sits beside the ALU in the execute stage and is used where shifter area or critical path matters more than shift latency.

## Interface
Parameters:
- WIDTH, 32, data width; must be a power of two.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request strobe; accepted when start && ready.
- ready  out  1  high when a request can be accepted (state IDLE or DONE).
- ctrl  in  2  mode: 00 SLL, 01 SRL, 11 SRA, 10 pass-through.
- shamt  in  SHAMT_W  shift amount.
- din  in  WIDTH  operand to shift.
- flush  in  1  abort the in-flight operation.
- busy  out  1  high in state SHIFT.
- done  out  1  one-cycle pulse, result valid.
- dout  out  WIDTH  result register; holds its value until the next completed operation.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start && !flush: latch din into the accumulator, and latch shamt and ctrl.
  - Load the stage counter with SHAMT_W-1, then go to SHIFT.
- SHIFT, once per cycle:
  - If shamt_q[cnt] is 1, the accumulator shifts by 2^cnt in the latched mode; otherwise it holds.
  - cnt decrements each cycle.
  - On the cnt==0 cycle: write the shifted value to dout and go to DONE.
- DONE:
  - done=1 for this one cycle.
  - start && !flush goes straight to SHIFT with new latched operands (back-to-back); otherwise go to IDLE.
- Mode behaviour:
  - SRA fills with accumulator bit WIDTH-1 at every stage, so the sign is preserved across stages.
  - SRL and SLL fill with zeros.
  - Mode 10 never modifies the accumulator.
- Fixed latency regardless of shamt or mode: shamt=0 and mode 10 still take all SHAMT_W stages.
- din, shamt and ctrl are sampled only on the acceptance edge; changes during SHIFT are ignored.
- flush:
  - In SHIFT: next state is IDLE, no done, dout unchanged.
  - In IDLE or DONE: suppresses acceptance of start; no other effect (a done pulse already driven in DONE stands).
- start while busy is ignored; no error is raised.

## Timing
- Request accepted at the edge ending cycle t.
- SHIFT occupies cycles t+1 .. t+SHAMT_W.
- done=1 and the new dout are visible in cycle t+SHAMT_W+1 (t+6 at default).
- Throughput: one request per SHAMT_W+1 cycles with back-to-back starts in DONE.
- ready, busy and done decode directly from the state register, with no combinational path from inputs.
- Reset values, asynchronous and immediate, including mid-operation:
  - state IDLE, accumulator 0, shamt_q 0, ctrl_q 00, cnt 0, dout 0.
  - done 0, busy 0, ready 1.
- An in-flight operation is lost on reset and no done is issued.

## Structure
- Shared package shift_pkg:
  - mode constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b11, SH_PASS=2'b10.
  - state encoding for IDLE, SHIFT, DONE.
- One combinational sub-module, shift_step.
  - Inputs: WIDTH operand, 2-bit mode, stage index, enable.
  - Output: the operand shifted by 2^index, or passed through when enable=0 or mode is SH_PASS.
- Top level holds the FSM, counter, latches and dout register.

## Test plan
- SLL: din=0x0000_0001, shamt=31 -> done at t+6, dout=0x8000_0000.
- SRA and SRL on din=0x8000_0000, shamt=4:
  - SRA -> dout=0xF800_0000.
  - SRL -> dout=0x0800_0000.
- Pass-through and zero shift, both with done at t+6:
  - ctrl=10, din=0xDEAD_BEEF, shamt=17 -> dout=0xDEAD_BEEF.
  - ctrl=00, shamt=0, din=0x1234_5678 -> dout=0x1234_5678.
- Flush:
  - Complete an operation leaving dout=0x0000_00F0.
  - Start a new one and assert flush in the third SHIFT cycle.
  - Expect no done, dout stays 0x0000_00F0, busy=0 and ready=1 the next cycle.
- Back-to-back: start asserted in the DONE cycle -> second done exactly 6 cycles after the first, each with the correct dout.
- Reset: assert rst during SHIFT -> dout=0, done=0, busy=0, ready=1 immediately; no done after release.
